// File: rtl/nabp_filter_fill_sequencer.sv
// Sequences one filtered-RAM fill per projection angle: clear the filter, stream
// host RAM addresses (with zero padding) through it, write centred results, signal done.
module nabp_filter_fill_sequencer #(
  parameter int unsigned ANGLE_WIDTH  = 9,
  parameter int unsigned S_WIDTH      = 9,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LINE_SIZE    = 256,
  parameter int unsigned FILTER_DELAY = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_start,
  input  logic [ANGLE_WIDTH-1:0] fill_angle,
  input  logic                   fill_abort,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic [ANGLE_WIDTH-1:0] fill_angle_q,
  output logic [S_WIDTH-1:0]     hs_s_val,
  output logic                   hs_pad,
  output logic                   filter_enable,
  output logic                   filter_clear,
  input  logic [DATA_WIDTH-1:0]  filter_out,
  output logic                   wr_en,
  output logic [S_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data
);

  localparam int unsigned LAT  = 1 + FILTER_DELAY;
  localparam int unsigned RD_W = $clog2(LINE_SIZE + FILTER_DELAY + 1);
  localparam int unsigned WR_W = $clog2(LINE_SIZE + 1);

  localparam logic [RD_W-1:0]    RD_LAST = RD_W'(LINE_SIZE + FILTER_DELAY - 1);
  localparam logic [RD_W-1:0]    RD_PAD  = RD_W'(LINE_SIZE);
  localparam logic [WR_W-1:0]    WR_LAST = WR_W'(LINE_SIZE - 1);
  localparam logic [S_WIDTH-1:0] S_LAST  = S_WIDTH'(LINE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [RD_W-1:0]        rd_q, rd_d;
  logic [WR_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [LAT-1:0]         valid_q, valid_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [S_WIDTH-1:0]     s_val_q, s_val_d;
  logic                   pad_q, pad_d;
  logic                   en_q, en_d;
  logic                   clr_q, clr_d;
  logic                   abort_now;
  logic                   issue;
  logic                   last_wr;

  always_comb begin
    abort_now = fill_abort && (state_q != S_IDLE);
    issue     = (state_q == S_FEED) && (rd_q < RD_PAD);
    last_wr   = valid_q[LAT-1] && (wr_cnt_q == WR_LAST);

    state_d = state_q;
    rd_d    = '0;
    angle_d = angle_q;

    unique case (state_q)
      S_IDLE: begin
        if (fill_start && !fill_abort) begin
          state_d = S_CLEAR;
          angle_d = fill_angle;
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (rd_q == RD_LAST) state_d = S_DRAIN;
        else                 rd_d    = rd_q + 1'b1;
      end
      S_DRAIN: begin
        if (last_wr) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_now) state_d = S_IDLE;

    valid_d    = valid_q << 1;
    valid_d[0] = issue;
    if (abort_now) valid_d = '0;

    wr_cnt_d = wr_cnt_q;
    if (valid_q[LAT-1]) wr_cnt_d = wr_cnt_q + 1'b1;
    if (abort_now || (state_d inside {S_IDLE, S_CLEAR, S_DONE})) wr_cnt_d = '0;

    // Outputs are decoded from next-state values so they can be registered
    // without adding a cycle of latency.
    busy_d = state_d inside {S_CLEAR, S_FEED, S_DRAIN};
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
    en_d   = state_d inside {S_FEED, S_DRAIN};
    pad_d  = ((state_d == S_FEED) && (rd_d >= RD_PAD)) || (state_d == S_DRAIN);

    s_val_d = '0;
    if (state_d == S_FEED)       s_val_d = (rd_d < RD_PAD) ? S_WIDTH'(rd_d) : S_LAST;
    else if (state_d == S_DRAIN) s_val_d = S_LAST;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      wr_cnt_q <= '0;
      valid_q  <= '0;
      angle_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_val_q  <= '0;
      pad_q    <= 1'b0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_cnt_q <= wr_cnt_d;
      valid_q  <= valid_d;
      angle_q  <= angle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      s_val_q  <= s_val_d;
      pad_q    <= pad_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
    end
  end

  // An abort clears the filter in the same cycle it is raised.
  assign filter_clear  = clr_q | abort_now;
  assign fill_busy     = busy_q;
  assign fill_done     = done_q;
  assign fill_angle_q  = angle_q;
  assign hs_s_val      = s_val_q;
  assign hs_pad        = pad_q;
  assign filter_enable = en_q;
  assign wr_en         = valid_q[LAT-1];
  assign wr_addr       = S_WIDTH'(wr_cnt_q);
  assign wr_data       = filter_out;

endmodule

// File: tb/tb_nabp_filter_fill_sequencer.sv
module tb_nabp_filter_fill_sequencer;
  localparam int unsigned AW = 9;
  localparam int unsigned SW = 9;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic          a_fill_start = 1'b0, a_fill_abort = 1'b0;
  logic [AW-1:0] a_fill_angle = '0;
  logic          a_fill_busy, a_fill_done, a_hs_pad, a_filter_enable, a_filter_clear, a_wr_en;
  logic [AW-1:0] a_fill_angle_q;
  logic [SW-1:0] a_hs_s_val, a_wr_addr;
  logic [DW-1:0] a_filter_out, a_wr_data;

  logic          b_fill_start = 1'b0, b_fill_abort = 1'b0;
  logic [AW-1:0] b_fill_angle = '0;
  logic          b_fill_busy, b_fill_done, b_hs_pad, b_filter_enable, b_filter_clear, b_wr_en;
  logic [AW-1:0] b_fill_angle_q;
  logic [SW-1:0] b_hs_s_val, b_wr_addr;
  logic [DW-1:0] b_filter_out, b_wr_data;

  nabp_filter_fill_sequencer #(
    .ANGLE_WIDTH(AW), .S_WIDTH(SW), .DATA_WIDTH(DW), .LINE_SIZE(8), .FILTER_DELAY(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .fill_start(a_fill_start), .fill_angle(a_fill_angle), .fill_abort(a_fill_abort),
    .fill_busy(a_fill_busy), .fill_done(a_fill_done), .fill_angle_q(a_fill_angle_q),
    .hs_s_val(a_hs_s_val), .hs_pad(a_hs_pad),
    .filter_enable(a_filter_enable), .filter_clear(a_filter_clear), .filter_out(a_filter_out),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  nabp_filter_fill_sequencer #(
    .ANGLE_WIDTH(AW), .S_WIDTH(SW), .DATA_WIDTH(DW), .LINE_SIZE(1), .FILTER_DELAY(0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .fill_start(b_fill_start), .fill_angle(b_fill_angle), .fill_abort(b_fill_abort),
    .fill_busy(b_fill_busy), .fill_done(b_fill_done), .fill_angle_q(b_fill_angle_q),
    .hs_s_val(b_hs_s_val), .hs_pad(b_hs_pad),
    .filter_enable(b_filter_enable), .filter_clear(b_filter_clear), .filter_out(b_filter_out),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  logic [DW-1:0] a_host = '0, a_dl0 = '0, a_dl1 = '0;
  logic [DW-1:0] b_host = '0;
  always @(posedge clk) begin
    a_host <= a_hs_pad ? '0 : DW'(a_hs_s_val) + DW'(a_fill_angle_q);
    a_dl0  <= a_host;
    a_dl1  <= a_dl0;
    b_host <= b_hs_pad ? '0 : DW'(b_hs_s_val) + DW'(b_fill_angle_q);
  end
  assign a_filter_out = a_dl1;
  assign b_filter_out = b_host;

  logic [SW-1:0] qa_addr[$];
  logic [DW-1:0] qa_data[$];
  logic          sb_a_on = 1'b1;

  task automatic push_a(input int unsigned ang, input int unsigned n);
    for (int unsigned s = 0; s < n; s++) begin
      qa_addr.push_back(SW'(s));
      qa_data.push_back(DW'(s + ang));
    end
  endtask

  task automatic check(input bit ok, input string what);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at time %0t", what, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (a_fill_done !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    checks++;
    if (a_fill_done !== 1'b1) begin
      failures++;
      $display("FAIL a wait for fill_done expired after %0d cycles", limit);
    end
  endtask

  always @(negedge clk) begin
    logic [SW-1:0] ea;
    logic [DW-1:0] ed;
    if (sb_a_on && a_wr_en === 1'b1) begin
      checks++;
      if (qa_addr.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_write addr=%0d data=%0d required=no write", a_wr_addr, a_wr_data);
      end else begin
        ea = qa_addr.pop_front();
        ed = qa_data.pop_front();
        if (a_wr_addr !== ea || a_wr_data !== ed) begin
          failures++;
          $display("FAIL a_write addr=%0d data=%0d required addr=%0d data=%0d",
                   a_wr_addr, a_wr_data, ea, ed);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check(a_fill_busy === 1'b0 && a_fill_done === 1'b0 && a_fill_angle_q === '0 &&
          a_hs_s_val === '0 && a_hs_pad === 1'b0 && a_filter_enable === 1'b0 &&
          a_filter_clear === 1'b0 && a_wr_en === 1'b0 && a_wr_addr === '0 &&
          a_wr_data === a_filter_out, "a reset outputs");
    check(b_fill_busy === 1'b0 && b_fill_done === 1'b0 && b_fill_angle_q === '0 &&
          b_hs_s_val === '0 && b_hs_pad === 1'b0 && b_filter_enable === 1'b0 &&
          b_filter_clear === 1'b0 && b_wr_en === 1'b0 && b_wr_addr === '0 &&
          b_wr_data === b_filter_out, "b reset outputs");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    cyc();
    cyc();
    check_reset_outputs();
    reset = 1'b0;
    cyc();
    check_reset_outputs();
  endtask

  task automatic test_basic();
    int unsigned wr_cnt;
    wr_cnt = 0;
    push_a(20, 8);
    for (int unsigned t = 0; t <= 15; t++) begin
      a_fill_start = (t == 0);
      a_fill_angle = 20;
      #1;
      check(a_filter_clear === (t == 1), "basic filter_clear");
      check(a_fill_busy === (t >= 1 && t <= 12), "basic fill_busy");
      check(a_fill_done === (t == 13), "basic fill_done");
      check(a_filter_enable === (t >= 2 && t <= 12), "basic filter_enable");
      check(a_wr_en === (t >= 5 && t <= 12), "basic wr_en");
      if (t >= 2 && t <= 9)
        check(a_hs_s_val === SW'(t - 2) && a_hs_pad === 1'b0, "basic read address");
      if (t >= 10 && t <= 12)
        check(a_hs_pad === 1'b1, "basic pad");
      if (t >= 5 && t <= 12)
        check(a_wr_addr === SW'(t - 5), "basic wr_addr");
      if (t >= 1)
        check(a_fill_angle_q === AW'(20), "basic fill_angle_q");
      if (a_wr_en === 1'b1) wr_cnt++;
      cyc();
    end
    a_fill_start = 1'b0;
    check(wr_cnt == 8, "basic write count");
    check(qa_addr.size() == 0, "basic scoreboard empty");
  endtask

  task automatic test_angles();
    for (int unsigned ang = 0; ang <= 80; ang += 20) begin
      push_a(ang, 8);
      a_fill_angle = AW'(ang);
      a_fill_start = 1'b1;
      cyc();
      a_fill_start = 1'b0;
      wait_done_a(40);
      check(a_fill_angle_q === AW'(ang), "angles fill_angle_q");
      cyc();
    end
    check(qa_addr.size() == 0, "angles scoreboard empty");
  endtask

  task automatic test_ignore_start();
    int unsigned clr_cnt, wr_cnt, done_cnt;
    clr_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    push_a(33, 8);
    for (int unsigned t = 0; t <= 20; t++) begin
      a_fill_start = (t == 0 || t == 4 || t == 13);
      a_fill_angle = (t == 0) ? AW'(33) : AW'(77);
      #1;
      if (a_filter_clear === 1'b1) clr_cnt++;
      if (a_wr_en === 1'b1) wr_cnt++;
      if (a_fill_done === 1'b1) done_cnt++;
      if (t >= 1)
        check(a_fill_angle_q === AW'(33), "ignore fill_angle_q unchanged");
      if (t >= 14)
        check(a_fill_busy === 1'b0, "ignore no restart");
      cyc();
    end
    a_fill_start = 1'b0;
    check(clr_cnt == 1, "ignore single clear");
    check(wr_cnt == 8, "ignore write count");
    check(done_cnt == 1, "ignore single done");
    check(qa_addr.size() == 0, "ignore scoreboard empty");
  endtask

  task automatic test_abort();
    int unsigned late_wr, done_cnt;
    late_wr = 0;
    done_cnt = 0;
    sb_a_on = 1'b0;
    for (int unsigned t = 0; t <= 23; t++) begin
      if (t == 9) begin
        push_a(60, 8);
        sb_a_on = 1'b1;
      end
      a_fill_start = (t == 0 || t == 9);
      a_fill_angle = (t < 9) ? AW'(40) : AW'(60);
      a_fill_abort = (t == 7);
      #1;
      if (t == 7)
        check(a_filter_clear === 1'b1, "abort filter_clear");
      if (t == 8)
        check(a_fill_busy === 1'b0 && a_filter_enable === 1'b0 && a_wr_en === 1'b0,
              "abort idle");
      if (t > 7 && t < 14 && a_wr_en === 1'b1) late_wr++;
      if (t <= 12 && a_fill_done === 1'b1) done_cnt++;
      if (t == 10)
        check(a_filter_clear === 1'b1, "abort restart clear");
      if (t == 22)
        check(a_fill_done === 1'b1, "abort restart done");
      cyc();
    end
    a_fill_start = 1'b0;
    a_fill_abort = 1'b0;
    check(late_wr == 0, "abort no late writes");
    check(done_cnt == 0, "abort no done");
    check(qa_addr.size() == 0, "abort restart scoreboard empty");
  endtask

  task automatic test_reset_mid();
    int unsigned wr_after, done_after;
    wr_after = 0;
    done_after = 0;
    sb_a_on = 1'b0;
    for (int unsigned t = 0; t <= 20; t++) begin
      a_fill_start = (t == 0);
      a_fill_angle = 50;
      if (t == 6) reset = 1'b1;
      if (t == 8) reset = 1'b0;
      #1;
      if (t == 6) check_reset_outputs();
      if (t >= 8) begin
        if (a_wr_en === 1'b1) wr_after++;
        if (a_fill_done === 1'b1) done_after++;
        check(a_fill_busy === 1'b0, "reset_mid stays idle");
      end
      cyc();
    end
    a_fill_start = 1'b0;
    check(wr_after == 0, "reset_mid no pending writes");
    check(done_after == 0, "reset_mid no done");
    qa_addr.delete();
    qa_data.delete();
    sb_a_on = 1'b1;
  endtask

  task automatic test_small();
    int unsigned wr_cnt;
    wr_cnt = 0;
    for (int unsigned t = 0; t <= 11; t++) begin
      b_fill_start = (t == 0 || t == 5);
      b_fill_angle = (t < 5) ? AW'(7) : AW'(9);
      #1;
      check(b_filter_clear === (t == 1 || t == 6), "small filter_clear");
      check(b_wr_en === (t == 3 || t == 8), "small wr_en");
      check(b_fill_done === (t == 4 || t == 9), "small fill_done");
      if (t == 2 || t == 7)
        check(b_hs_s_val === '0 && b_hs_pad === 1'b0 && b_filter_enable === 1'b1,
              "small read");
      if (t == 3)
        check(b_wr_addr === '0 && b_wr_data === DW'(7), "small first write");
      if (t == 8)
        check(b_wr_addr === '0 && b_wr_data === DW'(9), "small second write");
      if (b_wr_en === 1'b1) wr_cnt++;
      cyc();
    end
    b_fill_start = 1'b0;
    check(wr_cnt == 2, "small write count");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_angles();
    test_ignore_start();
    test_abort();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
